// File: rtl/cla_seq32.sv
// cla_seq32: sequential 32-bit add/subtract, one 4-bit carry-lookahead nibble per clock
module cla_seq32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  input  logic        sub,
  output logic [31:0] s,
  output logic        co,
  output logic        ovf,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, s_q, s_d;
  logic [2:0]  idx_q, idx_d;
  logic        cy_q, cy_d, co_q, co_d, ovf_q, ovf_d;
  logic [3:0]  na, nb, g, p, sum;
  logic [4:0]  c;
  // lookahead carries and sum for the nibble selected by the index
  always_comb begin
    na = opa_q[{idx_q, 2'b00} +: 4];
    nb = opb_q[{idx_q, 2'b00} +: 4];
    g = na & nb;
    p = na | nb;
    c[0] = cy_q;
    c[1] = g[0] | p[0] & c[0];
    c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & c[0];
    c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c[0];
    c[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
         | p[3] & p[2] & p[1] & p[0] & c[0];
    sum = na ^ nb ^ c[3:0];
  end
  // next-state: accept in IDLE, one nibble per RUN cycle, single-cycle DONE
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    cy_d = cy_q;
    idx_d = idx_q;
    s_d = s_q;
    co_d = co_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      opa_d = a;
      opb_d = sub ? ~b : b;
      cy_d = sub | ci;
      idx_d = 3'd0;
      s_d = '0;
      co_d = 1'b0;
      ovf_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d[{idx_q, 2'b00} +: 4] = sum;
      cy_d = c[4];
      idx_d = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        co_d = c[4];
        ovf_d = c[3] ^ c[4];
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      cy_q <= 1'b0;
      idx_q <= 3'd0;
      s_q <= '0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cy_q <= cy_d;
      idx_q <= idx_d;
      s_q <= s_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
    end
  end
  assign s = s_q;
  assign co = co_q;
  assign ovf = ovf_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule
